load_store_unit: RTL and testbench

//  Parametrised load/store unit between the core datapath and data memory. Takes one load/store

---
 rtl/load_store_unit_if.sv | 70 +++++++
 rtl/load_store_unit.sv | 278 +++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Interfaces that bundle the two buses of the load/store unit.
//
// load_store_unit_core_if: core-side request/response handshake.
//   master = core (drives req_*, receives req_ready, rsp_*, busy)
//   slave  = load_store_unit
//   req_valid/req_ready   request handshake
//   req_we, req_size      store flag, access size (byte/half/word/dword)
//   req_signed            sign-extend loads
//   req_addr, req_wdata   byte address, right-justified store data
//   rsp_valid             one-cycle response pulse
//   rsp_rdata, rsp_fault  extended load data, fault flag
//   busy                  transaction in progress (core stall)
//
// load_store_unit_mem_if: data-memory beat bus.
//   master = load_store_unit
//   slave  = memory
//   mem_addr              line-aligned address
//   mem_re, mem_we        read/write strobes, held until mem_ack
//   mem_be, mem_wdata     byte enables and lane-aligned store data
//   mem_rdata, mem_ack    read data and beat completion

interface load_store_unit_core_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_fault;
    logic              busy;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
    );
endinterface

interface load_store_unit_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_re;
    logic                mem_we;
    logic [DATA_W/8-1:0] mem_be;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;

    modport master (
        output mem_addr, mem_re, mem_we, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_re, mem_we, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between the core datapath and a DATA_W-wide little-endian
// data memory. Accepts one request per handshake, issues one or two mem beats
// with byte enables, and returns zero/sign-extended load data.
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   core   load_store_unit_core_if.slave (request/response handshake, busy)
//   mem    load_store_unit_mem_if.master (mem_addr/re/we/be/wdata, rdata/ack)
//
// States:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | ready for a request; decode, fault check, set up first beat
//   ST_BEAT0 | first (or only) beat strobed, waiting for mem_ack
//   ST_BEAT1 | second beat of a line-crossing access, waiting for mem_ack
//   ST_RESP  | rsp_valid pulse with registered rdata/fault

module load_store_unit #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter bit ALLOW_UNALIGNED = 1'b0,
    parameter int TIMEOUT         = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    load_store_unit_core_if.slave  core,
    load_store_unit_mem_if.master  mem
);

    localparam int NB    = DATA_W / 8;
    localparam int NB2   = 2 * NB;
    localparam int OFF_W = $clog2(NB);
    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    // Down-counter reload: the beat times out when it reaches zero without ack,
    // giving exactly TIMEOUT strobe cycles.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic              we_q,        we_d;
    logic [1:0]        size_q,      size_d;
    logic              signed_q,    signed_d;
    logic [OFF_W-1:0]  off_q,       off_d;
    logic              cross_q,     cross_d;
    logic [NB-1:0]     be_hi_q,     be_hi_d;
    logic [DATA_W-1:0] lo_q,        lo_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic              mem_re_q,    mem_re_d;
    logic              mem_we_q,    mem_we_d;
    logic [NB-1:0]     mem_be_q,    mem_be_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic [TMO_W-1:0]  tmo_cnt_q,   tmo_cnt_d;

    // Request decode
    logic [OFF_W-1:0]    req_off;
    logic [OFF_W-1:0]    size_lsb_mask;
    logic [NB2-1:0]      size_mask;
    logic [NB2-1:0]      lane_mask;
    logic                req_cross;
    logic                req_misaligned;
    logic                req_size_bad;
    logic                req_fault;
    logic [2*DATA_W-1:0] wdata_dup;
    logic [DATA_W-1:0]   wdata_rot;
    logic                tmo_expired;

    // Shift the assembled (one or two line) data down to the access offset,
    // then extend from the access size to DATA_W.
    function automatic logic [DATA_W-1:0] load_result(
        input logic [2*DATA_W-1:0] line,
        input logic [OFF_W-1:0]    off,
        input logic [1:0]          sz,
        input logic                sgn
    );
        logic [2*DATA_W-1:0] shifted;
        logic [DATA_W-1:0]   d;
        logic [DATA_W-1:0]   keep;
        logic                fill;
        shifted = line >> {off, 3'b000};
        d       = shifted[DATA_W-1:0];
        case (sz)
            2'd0:    begin keep = DATA_W'(8'hFF);         fill = sgn & d[7];  end
            2'd1:    begin keep = DATA_W'(16'hFFFF);      fill = sgn & d[15]; end
            2'd2:    begin keep = DATA_W'(32'hFFFF_FFFF); fill = sgn & d[31]; end
            default: begin keep = '1;                     fill = 1'b0;        end
        endcase
        return (d & keep) | (~keep & {DATA_W{fill}});
    endfunction

    always_comb begin
        req_off = core.req_addr[OFF_W-1:0];
        case (core.req_size)
            2'd0:    begin size_mask = NB2'(8'h01); size_lsb_mask = OFF_W'(0); end
            2'd1:    begin size_mask = NB2'(8'h03); size_lsb_mask = OFF_W'(1); end
            2'd2:    begin size_mask = NB2'(8'h0F); size_lsb_mask = OFF_W'(3); end
            default: begin size_mask = NB2'(8'hFF); size_lsb_mask = OFF_W'(7); end
        endcase
        // Lanes over two consecutive lines; any bit in the upper half means
        // the access spills into the next line.
        lane_mask      = size_mask << req_off;
        req_cross      = |lane_mask[NB2-1:NB];
        req_misaligned = |(req_off & size_lsb_mask);
        req_size_bad   = (core.req_size == 2'd3) && (DATA_W == 32);
        req_fault      = req_size_bad || (req_misaligned && !ALLOW_UNALIGNED);
        // Rotate left by offset bytes; the same word serves both beats because
        // the wrapped bytes land on the low lanes of the second line.
        wdata_dup      = {core.req_wdata, core.req_wdata} << {req_off, 3'b000};
        wdata_rot      = wdata_dup[2*DATA_W-1:DATA_W];
    end

    assign tmo_expired = (TIMEOUT != 0) && (tmo_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        signed_d    = signed_q;
        off_d       = off_q;
        cross_d     = cross_q;
        be_hi_d     = be_hi_q;
        lo_d        = lo_q;
        mem_addr_d  = mem_addr_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_fault_d = rsp_fault_q;
        tmo_cnt_d   = tmo_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (core.req_valid) begin
                    we_d        = core.req_we;
                    size_d      = core.req_size;
                    signed_d    = core.req_signed;
                    off_d       = req_off;
                    cross_d     = req_cross;
                    be_hi_d     = core.req_we ? lane_mask[NB2-1:NB] : '1;
                    rsp_rdata_d = '0;
                    if (req_fault) begin
                        state_d     = ST_RESP;
                        rsp_fault_d = 1'b1;
                    end else begin
                        state_d     = ST_BEAT0;
                        rsp_fault_d = 1'b0;
                        mem_addr_d  = {core.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mem_re_d    = ~core.req_we;
                        mem_we_d    = core.req_we;
                        // Loads fetch the whole line; stores enable only written bytes.
                        mem_be_d    = core.req_we ? lane_mask[NB-1:0] : '1;
                        mem_wdata_d = wdata_rot;
                        tmo_cnt_d   = TMO_LOAD;
                    end
                end
            end

            ST_BEAT0: begin
                if (mem.mem_ack) begin
                    if (cross_q) begin
                        state_d    = ST_BEAT1;
                        mem_addr_d = mem_addr_q + ADDR_W'(NB);
                        mem_be_d   = be_hi_q;
                        lo_d       = mem.mem_rdata;
                        tmo_cnt_d  = TMO_LOAD;
                    end else begin
                        state_d     = ST_RESP;
                        mem_re_d    = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_be_d    = '0;
                        rsp_rdata_d = we_q ? '0 :
                            load_result({{DATA_W{1'b0}}, mem.mem_rdata}, off_q, size_q, signed_q);
                    end
                end else if (tmo_expired) begin
                    state_d     = ST_RESP;
                    mem_re_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '0;
                    rsp_fault_d = 1'b1;
                    rsp_rdata_d = '0;
                end else if (TIMEOUT != 0) begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end

            ST_BEAT1: begin
                if (mem.mem_ack) begin
                    state_d     = ST_RESP;
                    mem_re_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '0;
                    rsp_rdata_d = we_q ? '0 :
                        load_result({mem.mem_rdata, lo_q}, off_q, size_q, signed_q);
                end else if (tmo_expired) begin
                    state_d     = ST_RESP;
                    mem_re_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '0;
                    rsp_fault_d = 1'b1;
                    rsp_rdata_d = '0;
                end else if (TIMEOUT != 0) begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end

            ST_RESP: begin
                // Response fields are cleared so they read zero outside the pulse.
                state_d     = ST_IDLE;
                rsp_rdata_d = '0;
                rsp_fault_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            signed_q    <= 1'b0;
            off_q       <= '0;
            cross_q     <= 1'b0;
            be_hi_q     <= '0;
            lo_q        <= '0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            off_q       <= off_d;
            cross_q     <= cross_d;
            be_hi_q     <= be_hi_d;
            lo_q        <= lo_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign core.req_ready = (state_q == ST_IDLE);
    assign core.busy      = (state_q != ST_IDLE);
    assign core.rsp_valid = (state_q == ST_RESP);
    assign core.rsp_rdata = rsp_rdata_q;
    assign core.rsp_fault = rsp_fault_q;

    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_re     = mem_re_q;
    assign mem.mem_we     = mem_we_q;
    assign mem.mem_be     = mem_be_q;
    assign mem.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit (DATA_W=32). dut_u: unaligned split allowed,
// TIMEOUT=8, backed by a byte-array memory with random ack delay and checked
// against a byte-addressed reference model. dut_s: strict alignment, no timeout.
`timescale 1ns/1ps
module tb_load_store_unit;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    load_store_unit_core_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) cu ();
    load_store_unit_mem_if  #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mu ();
    load_store_unit_core_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) cs ();
    load_store_unit_mem_if  #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ms ();

    load_store_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALLOW_UNALIGNED(1'b1), .TIMEOUT(8)) dut_u (
        .clock(clock), .reset(reset), .core(cu), .mem(mu));

    load_store_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALLOW_UNALIGNED(1'b0), .TIMEOUT(0)) dut_s (
        .clock(clock), .reset(reset), .core(cs), .mem(ms));

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_ack_cyc = 0;
    bit no_ack = 1'b0;
    logic [7:0]  mem_u   [0:511];
    logic [7:0]  ref_mem [0:511];
    logic [31:0] bq_addr[$];
    logic [3:0]  bq_be[$];
    logic [31:0] bq_wdata[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int a, input logic [31:0] v);
        for (int k = 0; k < 4; k++) begin
            mem_u[(a + k) & 511]   = v[8*k +: 8];
            ref_mem[(a + k) & 511] = v[8*k +: 8];
        end
    endtask

    // Memory behind dut_u: random 0..3 cycle ack delay, byte-lane writes.
    initial begin : mem_u_resp
        int wait_cnt;
        int base;
        logic [31:0] line;
        wait_cnt = 0;
        forever begin
            @(negedge clock);
            mu.mem_ack = 1'b0;
            if (reset && (mu.mem_re || mu.mem_we) && !no_ack) begin
                if (wait_cnt == 0) begin
                    base = int'(mu.mem_addr & 32'h1FF);
                    for (int k = 0; k < 4; k++) line[8*k +: 8] = mem_u[(base + k) & 511];
                    mu.mem_rdata = line;
                    if (mu.mem_we)
                        for (int k = 0; k < 4; k++)
                            if (mu.mem_be[k]) mem_u[(base + k) & 511] = mu.mem_wdata[8*k +: 8];
                    bq_addr.push_back(mu.mem_addr);
                    bq_be.push_back(mu.mem_be);
                    bq_wdata.push_back(mu.mem_wdata);
                    mu.mem_ack   = 1'b1;
                    last_ack_cyc = cyc;
                    wait_cnt     = int'($urandom_range(0, 3));
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Memory behind dut_s: immediate ack, fixed read data.
    initial begin : mem_s_resp
        forever begin
            @(negedge clock);
            ms.mem_ack   = ms.mem_re | ms.mem_we;
            ms.mem_rdata = 32'hCAFE_0180;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic drive_u(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
        cu.req_valid  = 1'b1;
        cu.req_we     = we;
        cu.req_size   = size;
        cu.req_signed = sgn;
        cu.req_addr   = addr;
        cu.req_wdata  = wdata;
    endtask

    // One request on dut_u with expectations from the byte-addressed model.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        logic [31:0] exp_data;
        logic        exp_fault;
        int          nb;
        bit          seen;
        nb        = 1 << size;
        exp_fault = (size == 2'd3);
        exp_data  = '0;
        if (!exp_fault && !we) begin
            for (int i = 0; i < nb; i++) exp_data[8*i +: 8] = ref_mem[(int'(addr) + i) & 511];
            if (sgn && exp_data[8*nb-1])
                for (int i = 8*nb; i < 32; i++) exp_data[i] = 1'b1;
        end
        if (!exp_fault && we)
            for (int i = 0; i < nb; i++) ref_mem[(int'(addr) + i) & 511] = wdata[8*i +: 8];

        @(negedge clock);
        chk_val({tag, "_ready"}, cu.req_ready, 1'b1);
        drive_u(we, size, sgn, addr, wdata);
        @(negedge clock);
        cu.req_valid = 1'b0;
        if (exp_fault)
            chk_val({tag, "_fault_lat"}, {cu.rsp_valid, mu.mem_re, mu.mem_we}, 3'b100);
        else
            chk_val({tag, "_strobe"}, {mu.mem_re, mu.mem_we}, {~we, we});
        seen = cu.rsp_valid;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clock);
            seen = cu.rsp_valid;
        end
        chk_val({tag, "_rsp_seen"}, seen, 1'b1);
        if (seen) begin
            if (!exp_fault) chk_val({tag, "_rsp_lat"}, cyc - last_ack_cyc, 1);
            chk_val({tag, "_fault"}, cu.rsp_fault, exp_fault);
            chk_val({tag, "_rdata"}, cu.rsp_rdata, exp_data);
            @(negedge clock);
            chk_val({tag, "_pulse"}, {cu.rsp_valid, cu.req_ready}, 2'b01);
        end
    endtask

    // One load on dut_s with hand-derived expectations.
    task automatic s_req(input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                         input string tag, input logic exp_fault, input logic [31:0] exp_data,
                         input int exp_lat);
        int acc;
        bit seen;
        bit strobe;
        @(negedge clock);
        cs.req_valid  = 1'b1;
        cs.req_we     = 1'b0;
        cs.req_size   = size;
        cs.req_signed = sgn;
        cs.req_addr   = addr;
        cs.req_wdata  = '0;
        acc = cyc;
        @(negedge clock);
        cs.req_valid = 1'b0;
        seen   = 1'b0;
        strobe = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (cs.rsp_valid) begin
                seen = 1'b1;
                break;
            end
            strobe |= ms.mem_re;
            @(negedge clock);
        end
        chk_val({tag, "_seen"},   seen, 1'b1);
        chk_val({tag, "_lat"},    cyc - acc, exp_lat);
        chk_val({tag, "_fault"},  cs.rsp_fault, exp_fault);
        chk_val({tag, "_rdata"},  cs.rsp_rdata, exp_data);
        chk_val({tag, "_strobe"}, strobe, !exp_fault);
    endtask

    initial begin : main
        int  strobe_cnt;
        bit  seen;
        int  bad;
        logic [31:0] w;

        cu.req_valid = 1'b0; cu.req_we = 1'b0; cu.req_size = 2'd0; cu.req_signed = 1'b0;
        cu.req_addr = '0; cu.req_wdata = '0;
        cs.req_valid = 1'b0; cs.req_we = 1'b0; cs.req_size = 2'd0; cs.req_signed = 1'b0;
        cs.req_addr = '0; cs.req_wdata = '0;
        mu.mem_ack = 1'b0; mu.mem_rdata = '0;
        ms.mem_ack = 1'b0; ms.mem_rdata = '0;
        for (int i = 0; i < 512; i++) begin
            mem_u[i]   = 8'($urandom);
            ref_mem[i] = mem_u[i];
        end

        repeat (3) @(negedge clock);
        chk_val("reset_ctl", {cu.req_ready, cu.busy, cu.rsp_valid, cu.rsp_fault}, 4'b1000);
        chk_val("reset_mem", {mu.mem_re, mu.mem_we, mu.mem_be}, 6'b0);
        chk_val("reset_rdata", cu.rsp_rdata, 32'h0);
        reset = 1'b1;

        // Signed byte load from the top lane
        set_word(32'h100, 32'h80FF_1234);
        bq_addr.delete(); bq_be.delete(); bq_wdata.delete();
        do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, "lb");
        chk_val("lb_nbeats", bq_addr.size(), 1);
        if (bq_addr.size() > 0) begin
            chk_val("lb_addr", bq_addr[0], 32'h100);
            chk_val("lb_be", bq_be[0], 4'b1111);
        end

        // Half store into upper lanes
        bq_addr.delete(); bq_be.delete(); bq_wdata.delete();
        do_req(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_ABCD, "sh");
        chk_val("sh_nbeats", bq_addr.size(), 1);
        if (bq_addr.size() > 0) begin
            w = bq_wdata[0];
            chk_val("sh_addr", bq_addr[0], 32'h200);
            chk_val("sh_be", bq_be[0], 4'b1100);
            chk_val("sh_wdata_hi", w[31:16], 16'hABCD);
        end

        // Line-crossing word load and store
        set_word(32'h100, 32'h1111_2222);
        set_word(32'h104, 32'h3333_4444);
        bq_addr.delete(); bq_be.delete(); bq_wdata.delete();
        do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, "lw_split");
        chk_val("lw_split_nbeats", bq_addr.size(), 2);
        if (bq_addr.size() > 1) begin
            chk_val("lw_split_addr0", bq_addr[0], 32'h100);
            chk_val("lw_split_addr1", bq_addr[1], 32'h104);
        end
        bq_addr.delete(); bq_be.delete(); bq_wdata.delete();
        do_req(1'b1, 2'd2, 1'b0, 32'h102, 32'h5566_7788, "sw_split");
        chk_val("sw_split_nbeats", bq_be.size(), 2);
        if (bq_be.size() > 1) begin
            chk_val("sw_split_be0", bq_be[0], 4'b1100);
            chk_val("sw_split_be1", bq_be[1], 4'b0011);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, "lw_after_sw");

        // Ack timeout after 8 strobe cycles, then a normal request
        no_ack = 1'b1;
        @(negedge clock);
        drive_u(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        @(negedge clock);
        cu.req_valid = 1'b0;
        strobe_cnt = 0;
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (cu.rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (mu.mem_re) strobe_cnt++;
            @(negedge clock);
        end
        chk_val("tmo_seen", seen, 1'b1);
        chk_val("tmo_strobe_cycles", strobe_cnt, 8);
        chk_val("tmo_fault", cu.rsp_fault, 1'b1);
        chk_val("tmo_rdata", cu.rsp_rdata, 32'h0);
        chk_val("tmo_strobe_dropped", mu.mem_re, 1'b0);
        no_ack = 1'b0;
        do_req(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, "after_tmo");

        // Reset in the middle of a beat
        no_ack = 1'b1;
        @(negedge clock);
        drive_u(1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
        @(negedge clock);
        cu.req_valid = 1'b0;
        chk_val("rst_mid_strobe_on", mu.mem_re, 1'b1);
        reset = 1'b0;
        #1;
        chk_val("rst_mid_outputs", {mu.mem_re, cu.busy, cu.req_ready, cu.rsp_valid}, 4'b0010);
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            chk_val("rst_mid_no_rsp", cu.rsp_valid, 1'b0);
        end
        reset  = 1'b1;
        no_ack = 1'b0;
        set_word(32'h0, 32'h0000_F00D);
        do_req(1'b0, 2'd1, 1'b0, 32'h0, 32'h0, "lhu_after_rst");

        // Strict-alignment instance
        s_req(2'd2, 1'b0, 32'h101, "s_lw_mis", 1'b1, 32'h0, 1);
        s_req(2'd1, 1'b1, 32'h102, "s_lh", 1'b0, 32'hFFFF_CAFE, 2);
        s_req(2'd0, 1'b0, 32'h101, "s_lbu", 1'b0, 32'h0000_0001, 2);

        // Random traffic against the byte model
        for (int n = 0; n < 300; n++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom),
                   32'h100 + $urandom_range(0, 32'hF7), $urandom, "rnd");
        end

        bad = 0;
        for (int i = 0; i < 512; i++) if (mem_u[i] !== ref_mem[i]) bad++;
        chk_val("mem_image", bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
